// File: rtl/invert8_pkg.sv
// Shared component constants for the invert8 NOT stage and its neighbours in
// ALU/logic datapaths.
package invert8_pkg;

  localparam int unsigned INV_WIDTH_DEFAULT = 8;
  localparam int unsigned INV_WIDTH_MAX     = 64;

  // Reset value of the registered result, sliced down to the instance width.
  localparam logic [INV_WIDTH_MAX-1:0] INV_FQ_RST = '0;

endpackage : invert8_pkg

// File: rtl/invert8_if.sv
// Signal bundle for an invert8 stage: the operand and load enable flow in, and
// both results flow out.
interface invert8_if
  import invert8_pkg::*;
#(
  parameter int unsigned WIDTH = INV_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] a;
  logic             en;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_q;

  modport master (output a, output en, input  f, input  f_q);
  modport slave  (input  a, input  en, output f, output f_q);

endinterface : invert8_if

// File: rtl/invert8.sv
// Bitwise inverter: zero-latency combinational F = ~A, plus a registered copy
// F_Q with load enable and asynchronous active-high reset.
module invert8
  import invert8_pkg::*;
#(
  parameter int unsigned WIDTH = INV_WIDTH_DEFAULT
) (
  output logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] A,
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  output logic [WIDTH-1:0] F_Q
);

  logic [WIDTH-1:0] fq_d;
  logic [WIDTH-1:0] fq_q;

  // Pure bitwise NOT, so an X/Z on one operand bit only disturbs that bit.
  assign F = ~A;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    fq_d = fq_q;
    if (EN) begin
      fq_d = ~A;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs from the same edge, regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fq_q <= INV_FQ_RST[WIDTH-1:0];
    end else begin
      fq_q <= fq_d;
    end
  end

  assign F_Q = fq_q;

endmodule : invert8

// File: tb/tb_invert8.sv
// Self-checking bench for invert8: combinational sweep, boundary words, async
// reset, registered latency/hold, randomized run against a model, WIDTH=16 chain.
module tb_invert8;

  int checks = 0;
  int errors = 0;

  logic clk     = 1'b0;
  logic clk_run = 1'b0;
  logic rst     = 1'b1;

  invert8_if #(.WIDTH(8)) inv_if ();

  invert8 #(.WIDTH(8)) u_dut (
    .F   (inv_if.f),
    .A   (inv_if.a),
    .clk (clk),
    .rst (rst),
    .EN  (inv_if.en),
    .F_Q (inv_if.f_q)
  );

  // WIDTH=16 double-inversion chain
  logic [15:0] a16, f16_a, f16_b, fq16_a, fq16_b;

  invert8 #(.WIDTH(16)) u_inv16_a (
    .F(f16_a), .A(a16), .clk(clk), .rst(rst), .EN(1'b1), .F_Q(fq16_a)
  );
  invert8 #(.WIDTH(16)) u_inv16_b (
    .F(f16_b), .A(f16_a), .clk(clk), .rst(rst), .EN(1'b1), .F_Q(fq16_b)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Reference: one's complement as (all-ones minus value) arithmetic.
  function automatic logic [7:0] ref_inv8(input int unsigned a);
    return 8'(255 - a);
  endfunction

  function automatic logic [15:0] ref_inv16(input int unsigned a);
    return 16'(65535 - a);
  endfunction

  logic [7:0] model_fq = 8'h00;

  task automatic test_reset();
    inv_if.a  = 8'h5A;
    inv_if.en = 1'b1;
    #1;
    checks++;
    if (inv_if.f_q !== 8'h00) begin
      $display("FAIL reset_fq: got %h expected 00", inv_if.f_q);
      errors++;
    end
    checks++;
    if (inv_if.f !== ref_inv8(8'h5A)) begin
      $display("FAIL reset_f_tracks: got %h expected %h", inv_if.f, ref_inv8(8'h5A));
      errors++;
    end
  endtask

  task automatic test_comb_sweep();
    for (int i = 0; i < 32; i++) begin
      inv_if.a = 8'(i);
      #10;
      checks++;
      if (inv_if.f !== ref_inv8(i)) begin
        $display("FAIL sweep A=%h: got %h expected %h", 8'(i), inv_if.f, ref_inv8(i));
        errors++;
      end
    end
  endtask

  task automatic test_boundary();
    logic [7:0] words [3] = '{8'hFF, 8'hAA, 8'h80};
    for (int i = 0; i < 3; i++) begin
      inv_if.a = words[i];
      #10;
      checks++;
      if (inv_if.f !== ref_inv8(words[i])) begin
        $display("FAIL boundary A=%h: got %h expected %h", words[i], inv_if.f, ref_inv8(words[i]));
        errors++;
      end
    end
  endtask

  // Drive at the falling edge, sample 1 ns after the rising edge.
  task automatic clock_and_check(input string name, input logic [7:0] exp_fq);
    @(posedge clk);
    #1;
    checks++;
    if (inv_if.f_q !== exp_fq) begin
      $display("FAIL %s: F_Q got %h expected %h", name, inv_if.f_q, exp_fq);
      errors++;
    end
  endtask

  task automatic test_latency();
    clk_run = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    inv_if.en = 1'b1;
    inv_if.a  = 8'h12;
    clock_and_check("latency_edge1", 8'hED);
    @(negedge clk);
    checks++;
    if (inv_if.f_q !== 8'hED) begin
      $display("FAIL latency_stable: F_Q got %h expected ED", inv_if.f_q);
      errors++;
    end
    inv_if.a = 8'h34;
    clock_and_check("latency_edge2", 8'hCB);
  endtask

  task automatic test_hold();
    @(negedge clk);
    inv_if.a = 8'h12;
    clock_and_check("hold_load", 8'hED);
    @(negedge clk);
    inv_if.en = 1'b0;
    inv_if.a  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      clock_and_check("hold_edge", 8'hED);
    end
    checks++;
    if (inv_if.f !== 8'hFF) begin
      $display("FAIL hold_f: got %h expected FF", inv_if.f);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    inv_if.en = 1'b1;
    inv_if.a  = 8'hC3;
    clock_and_check("rst_mid_preload", 8'h3C);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (inv_if.f_q !== 8'h00) begin
      $display("FAIL rst_mid_async: F_Q got %h expected 00", inv_if.f_q);
      errors++;
    end
    inv_if.a = 8'h0A;
    #1;
    checks++;
    if (inv_if.f !== 8'hF5) begin
      $display("FAIL rst_mid_f: got %h expected F5", inv_if.f);
      errors++;
    end
    clock_and_check("rst_overrides_en", 8'h00);
    @(negedge clk);
    rst      = 1'b0;
    inv_if.a = 8'h66;
    clock_and_check("rst_release_load", ref_inv8(8'h66));
    model_fq = ref_inv8(8'h66);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      inv_if.a  = 8'($urandom);
      inv_if.en = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 9) == 0);
      #1;
      if (rst) model_fq = 8'h00;
      checks++;
      if (inv_if.f !== ref_inv8(inv_if.a)) begin
        $display("FAIL rand_f A=%h: got %h expected %h", inv_if.a, inv_if.f, ref_inv8(inv_if.a));
        errors++;
      end
      checks++;
      if (inv_if.f_q !== model_fq) begin
        $display("FAIL rand_fq_pre: got %h expected %h", inv_if.f_q, model_fq);
        errors++;
      end
      @(posedge clk);
      #1;
      if (rst)            model_fq = 8'h00;
      else if (inv_if.en) model_fq = ref_inv8(inv_if.a);
      checks++;
      if (inv_if.f_q !== model_fq) begin
        $display("FAIL rand_fq A=%h EN=%b rst=%b: got %h expected %h",
                 inv_if.a, inv_if.en, rst, inv_if.f_q, model_fq);
        errors++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_width16();
    a16 = 16'h00F0;
    #1;
    checks++;
    if (f16_a !== 16'hFF0F) begin
      $display("FAIL w16_f: got %h expected FF0F", f16_a);
      errors++;
    end
    for (int i = 0; i < 100; i++) begin
      a16 = 16'($urandom);
      #1;
      checks++;
      if (f16_a !== ref_inv16(a16) || f16_b !== a16) begin
        $display("FAIL w16_chain A=%h: F=%h (expected %h) chain=%h (expected %h)",
                 a16, f16_a, ref_inv16(a16), f16_b, a16);
        errors++;
      end
    end
  endtask

  initial begin
    inv_if.a  = '0;
    inv_if.en = 1'b0;
    a16       = '0;
    test_reset();
    test_comb_sweep();
    test_boundary();
    test_latency();
    test_hold();
    test_reset_mid();
    test_random();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_invert8
